// File: rtl/dac_serializer_if.sv
// dac_serializer_if: parallel sample handshake between the DSP output and the DAC serializer.
interface dac_serializer_if #(parameter int SAMPLE_WIDTH = 16) ();
  logic [SAMPLE_WIDTH-1:0] sample_in;
  logic                    sample_valid;
  logic                    sample_ready;
  modport master (output sample_in, sample_valid, input sample_ready);
  modport slave  (input sample_in, sample_valid, output sample_ready);
endinterface

// File: rtl/dac_serializer.sv
// dac_serializer: buffers one mono sample and sends it MSB-first in both slots of a left-justified frame.
module dac_serializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BCLK_DIV     = 4
) (
  input  logic             sample_clock,
  input  logic             reset,
  dac_serializer_if.slave  s,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             underrun
);
  localparam int DW = $clog2(BCLK_DIV);
  localparam int CW = $clog2(2 * SAMPLE_WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(SAMPLE_WIDTH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * SAMPLE_WIDTH - 1);
  logic [DW-1:0]           div_q, div_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d, cur_q, cur_d, hold_q, hold_d, load;
  logic                    bclk_q, bclk_d, lrclk_q, lrclk_d, full_q, full_d, underrun_q, underrun_d;
  logic                    tick, fall, wrap, acc;
  always_comb begin
    tick       = div_q == DIV_LAST;
    fall       = tick && bclk_q;
    wrap       = fall && cnt_q == CNT_LAST;
    acc        = s.sample_valid && !full_q;
    div_d      = tick ? '0 : div_q + DW'(1);
    bclk_d     = bclk_q ^ tick;
    cnt_d      = !fall ? cnt_q : wrap ? '0 : cnt_q + CW'(1);
    lrclk_d    = cnt_d > CNT_MID;
    load       = full_q ? hold_q : '0;
    cur_d      = wrap ? load : cur_q;
    shift_d    = !fall ? shift_q : wrap ? load : cnt_q == CNT_MID ? cur_q : {shift_q[SAMPLE_WIDTH-2:0], 1'b0};
    hold_d     = acc ? s.sample_in : hold_q;
    full_d     = acc || (full_q && !wrap);
    underrun_d = wrap && !full_q;
  end
  always_ff @(posedge sample_clock) begin
    if (!reset) begin
      div_q      <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      cur_q      <= '0;
      hold_q     <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      full_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      cur_q      <= cur_d;
      hold_q     <= hold_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      full_q     <= full_d;
      underrun_q <= underrun_d;
    end
  end
  assign s.sample_ready = !full_q;
  assign bclk           = bclk_q;
  assign lrclk          = lrclk_q;
  assign sdata          = shift_q[SAMPLE_WIDTH-1];
  assign underrun       = underrun_q;
endmodule

// File: tb/tb_dac_serializer.sv
// tb_dac_serializer: directed stimulus with per-frame expectations checked by a serial-side monitor.
module tb_dac_serializer;
  typedef struct packed {
    logic [31:0] data;
    logic        ur;
  } exp_t;
  logic sample_clock = 1'b0;
  logic reset = 1'b0;
  logic bclk, lrclk, sdata, underrun;
  int   compared = 0;
  int   mismatched = 0;
  exp_t q[$];
  dac_serializer_if #(.SAMPLE_WIDTH(16)) sif ();
  dac_serializer #(.SAMPLE_WIDTH(16), .BCLK_DIV(4)) dut (
    .sample_clock(sample_clock),
    .reset(reset),
    .s(sif.slave),
    .bclk(bclk),
    .lrclk(lrclk),
    .sdata(sdata),
    .underrun(underrun)
  );
  always #5 sample_clock = ~sample_clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tmo(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask
  task automatic push(input logic [15:0] v, input logic ur);
    exp_t e;
    e.data = {v, v};
    e.ur   = ur;
    q.push_back(e);
  endtask
  task automatic send(input logic [15:0] v, input bit keep);
    int n;
    n = 0;
    @(negedge sample_clock);
    sif.sample_in    = v;
    sif.sample_valid = 1'b1;
    while (!sif.sample_ready && n < 1000) begin
      @(negedge sample_clock);
      n++;
    end
    if (n >= 1000) tmo("send");
    else begin
      @(posedge sample_clock);
      #1;
    end
    if (!keep) sif.sample_valid = 1'b0;
  endtask
  task automatic wait_lr(input logic lvl);
    int n;
    n = 0;
    while (lrclk === lvl && n < 600) begin
      @(negedge sample_clock);
      n++;
    end
    while (lrclk !== lvl && n < 600) begin
      @(negedge sample_clock);
      n++;
    end
    if (n >= 600) tmo("wait_lrclk");
  endtask
  task automatic wait_bfall(input int k);
    int n, f;
    logic pb;
    n = 0;
    f = 0;
    pb = bclk;
    while (f < k && n < 200) begin
      @(negedge sample_clock);
      n++;
      if (pb && !bclk) f++;
      pb = bclk;
    end
    if (f < k) tmo("wait_bclk_fall");
  endtask
  // monitor: collects one frame between lrclk falls, sampling sdata on each bclk rise
  initial begin
    logic        pb, plr;
    logic [31:0] dw, lw;
    int          nb, urc, fr;
    exp_t        e;
    fr = 0;
    pb = 1'b0;
    plr = 1'b0;
    nb = 0;
    urc = 0;
    dw = '0;
    lw = '0;
    forever begin
      @(negedge sample_clock);
      if (!reset) begin
        pb = 1'b0;
        plr = 1'b0;
        nb = 0;
        urc = 0;
        dw = '0;
        lw = '0;
      end else begin
        if (plr && !lrclk) begin
          compared++;
          if (q.size() == 0) begin
            mismatched++;
            $display("FAIL frame%0d: unexpected frame data %h", fr, dw);
          end else begin
            e = q.pop_front();
            if (nb != 32 || dw !== e.data || lw !== 32'h0000FFFF || urc != int'(e.ur)) begin
              mismatched++;
              $display("FAIL frame%0d: got bits=%0d data=%h lr=%h ur=%0d expected bits=32 data=%h lr=0000ffff ur=%0d",
                       fr, nb, dw, lw, urc, e.data, e.ur);
            end
          end
          fr++;
          nb = 0;
          urc = 0;
          dw = '0;
          lw = '0;
        end
        if (underrun === 1'b1) urc++;
        if (bclk && !pb) begin
          if (nb < 32) begin
            dw = {dw[30:0], sdata};
            lw = {lw[30:0], lrclk};
          end
          nb++;
        end
        pb = bclk;
        plr = lrclk;
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    sif.sample_in    = '0;
    sif.sample_valid = 1'b0;
    repeat (5) @(posedge sample_clock);
    @(negedge sample_clock);
    chk("rst_bclk", 32'(bclk), 0);
    chk("rst_lrclk", 32'(lrclk), 0);
    chk("rst_sdata", 32'(sdata), 0);
    chk("rst_ready", 32'(sif.sample_ready), 1);
    chk("rst_underrun", 32'(underrun), 0);
    push(16'h0000, 1'b0);
    reset = 1'b1;
    n = 0;
    do begin
      @(posedge sample_clock);
      #1;
      n++;
    end while (!bclk && n < 20);
    chk("first_rise", n, 4);
    n = 0;
    do begin
      @(posedge sample_clock);
      #1;
      n++;
    end while (bclk && n < 20);
    do begin
      @(posedge sample_clock);
      #1;
      n++;
    end while (!bclk && n < 40);
    chk("bclk_period", n, 8);
    send(16'hA5C3, 1'b0);
    push(16'hA5C3, 1'b0);
    send(16'h8000, 1'b1);
    push(16'h8000, 1'b0);
    send(16'h7FFF, 1'b1);
    push(16'h7FFF, 1'b0);
    send(16'h0001, 1'b1);
    push(16'h0001, 1'b0);
    send(16'h1234, 1'b0);
    push(16'h1234, 1'b0);
    push(16'h0000, 1'b1);
    wait_lr(1'b0);
    wait_lr(1'b0);
    send(16'h4321, 1'b0);
    push(16'h4321, 1'b0);
    wait_lr(1'b0);
    wait_lr(1'b1);
    // offer a sample exactly on the frame-start edge while the holding register is empty
    repeat (127) @(posedge sample_clock);
    #1;
    chk("ready_before_load", 32'(sif.sample_ready), 1);
    sif.sample_in    = 16'h0F0F;
    sif.sample_valid = 1'b1;
    push(16'h0000, 1'b1);
    push(16'h0F0F, 1'b0);
    @(posedge sample_clock);
    #1;
    sif.sample_valid = 1'b0;
    chk("load_underrun", 32'(underrun), 1);
    chk("held_after_load", 32'(sif.sample_ready), 0);
    send(16'hDEAD, 1'b0);
    send(16'hBEEF, 1'b0);
    wait_lr(1'b1);
    wait_bfall(4);
    reset = 1'b0;
    @(posedge sample_clock);
    @(negedge sample_clock);
    chk("mid_bclk", 32'(bclk), 0);
    chk("mid_lrclk", 32'(lrclk), 0);
    chk("mid_sdata", 32'(sdata), 0);
    chk("mid_ready", 32'(sif.sample_ready), 1);
    chk("mid_underrun", 32'(underrun), 0);
    repeat (2) @(negedge sample_clock);
    push(16'h0000, 1'b0);
    push(16'h0000, 1'b1);
    reset = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 1500) begin
      @(negedge sample_clock);
      n++;
    end
    if (q.size() != 0) tmo("drain");
    repeat (10) @(negedge sample_clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
